// File: rtl/dff_bank_arbiter_pkg.sv
// Shared definitions for the flip-flop bank write arbiter: FSM state
// encoding and a constant-evaluable ceil(log2) used for index widths.
package dff_bank_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Number of bits needed to index 'value' items; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_priority_pick.sv
// Combinational round-robin selector: starting one past last_grant_i and
// wrapping modulo NUM_REQ, report the first asserted request.
module rr_priority_pick
    import dff_bank_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] cand_idx;
    int               cand;

    // Scan every requester once in rotating order; modulo keeps the wrap
    // correct for requester counts that are not a power of two.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(last_grant_i) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                valid_o  = 1'b1;
                winner_o = cand_idx;
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter in front of a small bank of flip-flop registers.
// One requester is granted at a time; its address/data are staged, written,
// and acknowledged with a one-cycle pulse. A combinational read port exposes
// the bank contents.
module dff_bank_arbiter
    import dff_bank_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_in,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0]         rd_addr_in,
    output logic [NUM_REQ-1:0]        gnt_out,
    output logic [NUM_REQ-1:0]        ack_out,
    output logic [DATA_W-1:0]         rd_data_out,
    output logic                      busy_out
);

    localparam int IDX_W = clog2(NUM_REQ);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    winner_q, winner_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic [ADDR_W-1:0]   stg_addr_q, stg_addr_d;
    logic [DATA_W-1:0]   stg_data_q, stg_data_d;
    logic                bank_we;

    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;

    logic [ADDR_W-1:0]   req_addr [NUM_REQ];
    logic [DATA_W-1:0]   req_data [NUM_REQ];
    logic [DATA_W-1:0]   bank     [DEPTH];
    logic                rd_in_range;

    // Split the packed request buses into per-requester fields.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_addr[gi] = addr_in[gi*ADDR_W +: ADDR_W];
        assign req_data[gi] = data_in[gi*DATA_W +: DATA_W];
    end

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i        (req_in),
        .last_grant_i (last_grant_q),
        .winner_o     (pick_idx),
        .valid_o      (pick_valid)
    );

    // FSM and staging registers; reset discards any staged write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            winner_q     <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            gnt_q        <= '0;
            ack_q        <= '0;
            stg_addr_q   <= '0;
            stg_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            stg_addr_q   <= stg_addr_d;
            stg_data_q   <= stg_data_d;
        end
    end

    // Next-state logic: IDLE picks a winner, GRANT captures (or abandons on
    // withdrawal), WRITE commits the staged data and rotates priority.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        ack_d        = '0;
        stg_addr_d   = stg_addr_q;
        stg_data_d   = stg_data_q;
        bank_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    winner_d        = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    state_d         = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (req_in[winner_q]) begin
                    stg_addr_d      = req_addr[winner_q];
                    stg_data_d      = req_data[winner_q];
                    ack_d[winner_q] = 1'b1;
                    state_d         = ST_WRITE;
                end else begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                bank_we      = 1'b1;
                gnt_d        = '0;
                last_grant_d = winner_q;
                state_d      = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bank entries; an out-of-range staged address matches no entry, so the
    // write is silently dropped while the ack still goes out.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bank
        logic [DATA_W-1:0] entry_q;

        // Single bank register, written only in the WRITE cycle.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                entry_q <= '0;
            end else if (bank_we && (stg_addr_q == ADDR_W'(gi))) begin
                entry_q <= stg_data_q;
            end
        end

        assign bank[gi] = entry_q;
    end

    assign rd_in_range = (int'(rd_addr_in) < DEPTH);
    assign rd_data_out = rd_in_range ? bank[rd_addr_in] : '0;
    assign gnt_out     = gnt_q;
    assign ack_out     = ack_q;
    assign busy_out    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Testbench for dff_bank_arbiter: directed scenarios followed by randomized
// requester traffic, all checked against a transaction-level reference model.
module tb_dff_bank_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 2;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_in;
    logic [NUM_REQ*ADDR_W-1:0] addr_in;
    logic [NUM_REQ*DATA_W-1:0] data_in;
    logic [ADDR_W-1:0]         rd_addr_in;
    logic [NUM_REQ-1:0]        gnt_out;
    logic [NUM_REQ-1:0]        ack_out;
    logic [DATA_W-1:0]         rd_data_out;
    logic                      busy_out;

    dff_bank_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_in      (req_in),
        .addr_in     (addr_in),
        .data_in     (data_in),
        .rd_addr_in  (rd_addr_in),
        .gnt_out     (gnt_out),
        .ack_out     (ack_out),
        .rd_data_out (rd_data_out),
        .busy_out    (busy_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Requester-side view: what each requester currently wants to write.
    bit want  [NUM_REQ];
    int raddr [NUM_REQ];
    int rdata [NUM_REQ];
    logic [NUM_REQ-1:0] ack_seen;

    // Reference model: one transaction in flight, described by how far it
    // has progressed (0 none, 1 granted, 2 writing) and who owns it.
    int m_stage;
    int m_who;
    int m_last;
    int m_addr;
    int m_data;
    int m_bank [DEPTH];

    int ack_log [$];
    int ack_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_in[i]                    = want[i];
            addr_in[i*ADDR_W +: ADDR_W]  = ADDR_W'(raddr[i]);
            data_in[i*DATA_W +: DATA_W]  = DATA_W'(rdata[i]);
        end
    endtask

    task automatic model_reset();
        m_stage  = 0;
        m_who    = 0;
        m_last   = NUM_REQ - 1;
        m_addr   = 0;
        m_data   = 0;
        ack_seen = '0;
        for (int a = 0; a < DEPTH; a++) m_bank[a] = 0;
    endtask

    // Round-robin choice from the rules: first request at last+1, last+2, ...
    function automatic int rr_pick(input logic [NUM_REQ-1:0] req);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int j;
            j = (m_last + k) % NUM_REQ;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge given the requests seen at that edge.
    task automatic model_step();
        int w;
        if (m_stage == 0) begin
            w = rr_pick(req_in);
            if (w >= 0) begin
                m_who   = w;
                m_stage = 1;
            end
        end else if (m_stage == 1) begin
            if (req_in[m_who]) begin
                m_addr  = raddr[m_who];
                m_data  = rdata[m_who];
                m_stage = 2;
            end else begin
                m_stage = 0;
            end
        end else begin
            if (m_addr < DEPTH) m_bank[m_addr] = m_data;
            m_last  = m_who;
            m_stage = 0;
        end
    endtask

    // One clock: check outputs mid-cycle, advance model, then let requesters
    // react to any ack just after the edge.
    task automatic tick();
        int exp_gnt;
        int exp_ack;
        int exp_rd;
        @(negedge clk);
        cyc++;
        exp_gnt = (m_stage != 0) ? (1 << m_who) : 0;
        exp_ack = (m_stage == 2) ? (1 << m_who) : 0;
        exp_rd  = (int'(rd_addr_in) < DEPTH) ? m_bank[rd_addr_in] : 0;
        chk("gnt",  32'(gnt_out), exp_gnt);
        chk("ack",  32'(ack_out), exp_ack);
        chk("busy", 32'(busy_out), (m_stage != 0) ? 1 : 0);
        chk("rd",   32'(rd_data_out), exp_rd);
        ack_seen = ack_out;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack_out[i]) begin
                ack_log.push_back(i);
                ack_cyc.push_back(cyc);
                $display("[TB] cyc %0d write req %0d addr %0d data %02h", cyc, i, m_addr, m_data);
            end
        end
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) if (ack_seen[i]) want[i] = 1'b0;
        apply();
    endtask

    task automatic wait_acks(input int n, input int budget);
        int k;
        k = 0;
        while (ack_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (ack_log.size() < n) chk("ack_timeout", ack_log.size(), n);
    endtask

    task automatic clear_logs();
        ack_log.delete();
        ack_cyc.delete();
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) want[i] = 1'b0;
        apply();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int start;
        int k;
        reset_n    = 1'b0;
        rd_addr_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            want[i]  = 1'b0;
            raddr[i] = 0;
            rdata[i] = 0;
        end
        apply();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state: every entry reads zero, nothing granted.
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr_in = ADDR_W'(a);
            tick();
        end

        // Single write by requester 1.
        clear_logs();
        want[1] = 1'b1; raddr[1] = 2; rdata[1] = 'hA5;
        apply();
        start = cyc;
        wait_acks(1, 20);
        if (ack_log.size() >= 1) begin
            chk("single_who", ack_log[0], 1);
            chk("single_lat", ack_cyc[0] - start, 3);
        end
        rd_addr_in = 2;
        tick();
        chk("single_rd", 32'(rd_data_out), 'hA5);

        // Contention from a fresh reset: acks 0,1,2,3 spaced three cycles.
        pulse_reset();
        clear_logs();
        for (int i = 0; i < NUM_REQ; i++) begin
            want[i] = 1'b1; raddr[i] = i; rdata[i] = 'h10 + i;
        end
        apply();
        wait_acks(4, 40);
        if (ack_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("cont_order", ack_log[i], i);
            for (int i = 1; i < 4; i++) chk("cont_gap", ack_cyc[i] - ack_cyc[i-1], 3);
        end
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr_in = ADDR_W'(a);
            tick();
            chk("cont_bank", 32'(rd_data_out), 'h10 + a);
        end

        // Fairness wrap: after requester 3 was last served, 0 beats 3.
        clear_logs();
        want[0] = 1'b1; raddr[0] = 0; rdata[0] = 'h20;
        want[3] = 1'b1; raddr[3] = 3; rdata[3] = 'h23;
        apply();
        wait_acks(2, 30);
        if (ack_log.size() >= 2) begin
            chk("wrap_first", ack_log[0], 0);
            chk("wrap_second", ack_log[1], 3);
        end

        // Withdraw: requester 2 drops its request while granted.
        clear_logs();
        rd_addr_in = 2;
        want[2] = 1'b1; raddr[2] = 2; rdata[2] = 'h77;
        apply();
        k = 0;
        while (!(m_stage == 1 && m_who == 2) && k < 10) begin
            tick();
            k++;
        end
        chk("wd_granted", 32'(gnt_out), 32'b0100);
        want[2] = 1'b0;
        apply();
        tick();
        chk("wd_idle", 32'(busy_out), 0);
        repeat (3) tick();
        chk("wd_noack", ack_log.size(), 0);
        chk("wd_bank", 32'(rd_data_out), 'h12);

        // Reset during the WRITE cycle: staged write and ack are discarded.
        clear_logs();
        rd_addr_in = 1;
        want[1] = 1'b1; raddr[1] = 1; rdata[1] = 'hFF;
        apply();
        k = 0;
        while (m_stage != 2 && k < 10) begin
            tick();
            k++;
        end
        chk("mid_gnt_pre", 32'(gnt_out), 32'b0010);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_gnt", 32'(gnt_out), 0);
        chk("mid_ack", 32'(ack_out), 0);
        chk("mid_busy", 32'(busy_out), 0);
        for (int i = 0; i < NUM_REQ; i++) want[i] = 1'b0;
        apply();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        chk("mid_bank1", 32'(rd_data_out), 0);
        repeat (2) tick();
        chk("mid_noack", ack_log.size(), 0);

        // Randomized traffic with occasional withdrawal while granted.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!want[i] && !ack_seen[i] && ($urandom % 4 == 0)) begin
                    want[i]  = 1'b1;
                    raddr[i] = int'($urandom % (1 << ADDR_W));
                    rdata[i] = int'($urandom % (1 << DATA_W));
                end else if (want[i] && m_stage == 1 && m_who == i && ($urandom % 8 == 0)) begin
                    want[i] = 1'b0;
                end
            end
            rd_addr_in = ADDR_W'($urandom % (1 << ADDR_W));
            apply();
            tick();
        end

        // Drain outstanding requests.
        for (int i = 0; i < NUM_REQ; i++) want[i] = 1'b0;
        apply();
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
